// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet parser: FSM state encoding,
// error codes reported on err_code, and the default start-of-packet marker.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_payload_buf.sv
// Payload storage for the packet parser: DEPTH x 8 register file with a
// synchronous write port and an asynchronous read port; contents are never reset.
module uart_payload_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_packet_parser.sv
// Frames SYNC/CMD/LEN/PAYLOAD/CHK byte packets from the UART receive path and holds
// a validated packet until acked. Define UART_PARSER_TIMEOUT_EN for the inter-byte timeout.
module uart_packet_parser
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rx_data,
   input  logic                       data_ready,
   output logic                       pkt_valid,
   input  logic                       pkt_ack,
   output logic [7:0]                 pkt_cmd,
   output logic [7:0]                 pkt_len,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   output logic [7:0]                 rd_data,
   output logic                       pkt_err,
   output logic [1:0]                 err_code,
   output logic                       overrun,
   output logic [2:0]                 dbg_state
);

   localparam int         AW        = $clog2(MAX_LEN);
   localparam logic [7:0] LEN_LIMIT = 8'(MAX_LEN);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_chk, w_chk_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_cmd, w_cmd_nxt;
   logic [7:0] r_len, w_len_nxt;
   logic [1:0] r_err_code, w_err_code_nxt;
   logic       r_pkt_err, w_err;
   logic       r_overrun, w_ovr;
   logic       w_we;
   logic       w_tmo_hit;

`ifdef UART_PARSER_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_tmo;
   logic          w_in_pkt;

   assign w_in_pkt  = (r_state == CMD) || (r_state == LEN) ||
                      (r_state == PAYLOAD) || (r_state == CHK);
   // A byte arriving on the limit cycle takes priority over the timeout.
   assign w_tmo_hit = w_in_pkt && !data_ready && (r_tmo == TMO_LAST);

   always_ff @(posedge clk) begin
      if (reset || data_ready || !w_in_pkt || w_tmo_hit) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + TW'(1);
      end
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
   assign w_tmo_hit    = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_chk_nxt      = r_chk;
      w_cnt_nxt      = r_cnt;
      w_cmd_nxt      = r_cmd;
      w_len_nxt      = r_len;
      w_err_code_nxt = r_err_code;
      w_err          = 1'b0;
      w_ovr          = 1'b0;
      w_we           = 1'b0;
      if (r_state == DONE) begin
         // Bytes arriving while the packet is held are dropped, even on the ack cycle.
         w_ovr = data_ready;
         if (pkt_ack) begin
            w_state_nxt = IDLE;
         end
      end else if (data_ready) begin
         case (r_state)
            IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  w_state_nxt = CMD;
               end
            end
            CMD: begin
               w_cmd_nxt   = rx_data;
               w_chk_nxt   = rx_data;
               w_state_nxt = LEN;
            end
            LEN: begin
               w_chk_nxt = r_chk ^ rx_data;
               if (rx_data > LEN_LIMIT) begin
                  w_err          = 1'b1;
                  w_err_code_nxt = ERR_LEN;
                  w_state_nxt    = IDLE;
               end else if (rx_data == 8'd0) begin
                  w_len_nxt   = 8'd0;
                  w_state_nxt = CHK;
               end else begin
                  w_len_nxt   = rx_data;
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = PAYLOAD;
               end
            end
            PAYLOAD: begin
               w_we      = 1'b1;
               w_chk_nxt = r_chk ^ rx_data;
               w_cnt_nxt = r_cnt + 8'd1;
               if (r_cnt == r_len - 8'd1) begin
                  w_state_nxt = CHK;
               end
            end
            CHK: begin
               if (rx_data == r_chk) begin
                  w_state_nxt = DONE;
               end else begin
                  w_err          = 1'b1;
                  w_err_code_nxt = ERR_CHK;
                  w_state_nxt    = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end else if (w_tmo_hit) begin
         w_err          = 1'b1;
         w_err_code_nxt = ERR_TIMEOUT;
         w_state_nxt    = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_chk      <= 8'd0;
         r_cnt      <= 8'd0;
         r_cmd      <= 8'd0;
         r_len      <= 8'd0;
         r_err_code <= 2'b00;
         r_pkt_err  <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_chk      <= w_chk_nxt;
         r_cnt      <= w_cnt_nxt;
         r_cmd      <= w_cmd_nxt;
         r_len      <= w_len_nxt;
         r_err_code <= w_err_code_nxt;
         r_pkt_err  <= w_err;
         r_overrun  <= w_ovr;
      end
   end

   uart_payload_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .i_clk     (clk),
      .i_we      (w_we & ~reset),
      .i_wr_addr (r_cnt[AW-1:0]),
      .i_wr_data (rx_data),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

   assign pkt_valid = (r_state == DONE);
   assign pkt_cmd   = r_cmd;
   assign pkt_len   = r_len;
   assign pkt_err   = r_pkt_err;
   assign err_code  = r_err_code;
   assign overrun   = r_overrun;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Randomized bench for uart_packet_parser: packet-level reference model feeds an
// expected-event queue that a monitor drains as the DUT raises valid/err/overrun.
module tb_uart_packet_parser;
   import uart_pkg::*;

   localparam int MAX_LEN = 16;
   localparam int AW      = 4;
   localparam int TMO     = 100;
   localparam int EW      = 52;
   localparam logic [1:0] K_PKT = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;
   localparam logic [1:0] K_OVR = 2'd3;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          data_ready;
   logic          pkt_valid;
   logic          pkt_ack;
   logic [7:0]    pkt_cmd;
   logic [7:0]    pkt_len;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          pkt_err;
   logic [1:0]    err_code;
   logic          overrun;
   logic [2:0]    dbg_state;

   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [7:0]    exp_pay_q[$];

   uart_packet_parser #(
      .SYNC_BYTE      (8'hA5),
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .data_ready (data_ready),
      .pkt_valid  (pkt_valid),
      .pkt_ack    (pkt_ack),
      .pkt_cmd    (pkt_cmd),
      .pkt_len    (pkt_len),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .pkt_err    (pkt_err),
      .err_code   (err_code),
      .overrun    (overrun),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #50 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(100 * 60000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [EW-1:0] evt(input logic [1:0] k, input logic [1:0] c,
                                         input logic [7:0] cm, input logic [7:0] ln,
                                         input int unsigned cy);
      return {k, c, cm, ln, cy[31:0]};
   endfunction

   // Checksum rule: XOR of CMD, LEN and every payload byte.
   function automatic logic [7:0] model_chk(input logic [7:0] cmd, input logic [7:0] len,
                                            input logic [7:0] pay[$]);
      logic [7:0] c;
      c = cmd ^ len;
      foreach (pay[i]) c = c ^ pay[i];
      return c;
   endfunction

   task automatic pop_cmp(input string name, input logic [EW-1:0] act, output logic [EW-1:0] e);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got unexpected event %h, expected none", name, act);
         e = act;
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [EW-1:0] e;
      logic          seen;
      logic [7:0]    cur_cmd, cur_len;
      logic [7:0]    cur_pay [MAX_LEN];
      logic          ok;
      seen    = 1'b0;
      rd_addr = '0;
      cur_cmd = 8'd0;
      cur_len = 8'd0;
      forever begin
         @(negedge clk);
         if (!pkt_valid) seen = 1'b0;
         if (pkt_err) pop_cmp("pkt_err", evt(K_ERR, err_code, 8'd0, 8'd0, cyc), e);
         if (pkt_valid && !seen) begin
            pop_cmp("pkt_valid", evt(K_PKT, 2'b00, pkt_cmd, pkt_len, cyc), e);
            cur_cmd = e[47:40];
            cur_len = e[39:32];
            for (int i = 0; i < MAX_LEN; i++) begin
               if (i < int'(cur_len)) cur_pay[i] = (exp_pay_q.size() > 0) ? exp_pay_q.pop_front() : 8'hxx;
            end
            seen = 1'b1;
         end
         if (pkt_valid) begin
            ok = (pkt_cmd === cur_cmd) && (pkt_len === cur_len);
            for (int i = 0; i < MAX_LEN && i < int'(cur_len); i++) begin
               rd_addr = AW'(i);
               #1;
               if (rd_data !== cur_pay[i]) ok = 1'b0;
            end
            check("pkt_hold", ok, 1'b1);
         end
         if (overrun) pop_cmp("overrun", evt(K_OVR, 2'b00, 8'd0, 8'd0, cyc), e);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      rx_data    = b;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      rx_data    = 8'($urandom);
   endtask

   task automatic consume(input int ov_n, input bit ack_with_byte);
      for (int i = 0; i < 8 && !pkt_valid; i++) @(negedge clk);
      check("valid_wait", pkt_valid, 1'b1);
      idle($urandom_range(0, 3));
      repeat (ov_n) begin
         exp_q.push_back(evt(K_OVR, 2'b00, 8'd0, 8'd0, cyc + 1));
         drive_byte(8'($urandom));
         idle($urandom_range(0, 1));
      end
      pkt_ack = 1'b1;
      if (ack_with_byte) begin
         exp_q.push_back(evt(K_OVR, 2'b00, 8'd0, 8'd0, cyc + 1));
         rx_data    = 8'($urandom);
         data_ready = 1'b1;
      end
      @(negedge clk);
      pkt_ack    = 1'b0;
      data_ready = 1'b0;
      check("ack_release", pkt_valid, 1'b0);
   endtask

   task automatic send_packet(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] pay[$], input logic [7:0] chk,
                              input int noise_n, input int ov_n, input bit ack_with_byte);
      logic [7:0] b;
      for (int i = 0; i < noise_n; i++) begin
         do b = 8'($urandom); while (b == 8'hA5);
         drive_byte(b);
         idle($urandom_range(0, 2));
      end
      drive_byte(8'hA5);
      idle($urandom_range(0, 2));
      drive_byte(cmd);
      idle($urandom_range(0, 2));
      if (int'(len) > MAX_LEN) begin
         exp_q.push_back(evt(K_ERR, ERR_LEN, 8'd0, 8'd0, cyc + 1));
         drive_byte(len);
         idle(2);
         return;
      end
      drive_byte(len);
      for (int i = 0; i < int'(len); i++) begin
         idle($urandom_range(0, 2));
         drive_byte(pay[i]);
      end
      idle($urandom_range(0, 2));
      if (chk != model_chk(cmd, len, pay)) begin
         exp_q.push_back(evt(K_ERR, ERR_CHK, 8'd0, 8'd0, cyc + 1));
         drive_byte(chk);
         idle(2);
         return;
      end
      exp_q.push_back(evt(K_PKT, 2'b00, cmd, len, cyc + 1));
      foreach (pay[i]) exp_pay_q.push_back(pay[i]);
      drive_byte(chk);
      consume(ov_n, ack_with_byte);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [7:0] q[$];
      logic [7:0] cmd, len, chk;
      int         r;
      reset      = 1'b1;
      data_ready = 1'b0;
      pkt_ack    = 1'b0;
      rx_data    = 8'd0;
      idle(3);
      check("rst_valid", pkt_valid, 1'b0);
      check("rst_err", {pkt_err, err_code, overrun}, 4'b0);
      check("rst_cmd_len", {pkt_cmd, pkt_len}, 16'h0000);
      check("rst_state", dbg_state, IDLE);
      reset = 1'b0;
      idle(2);

      // Good packet: A5 03 02 11 22 32
      q = {8'h11, 8'h22};
      send_packet(8'h03, 8'h02, q, 8'h32, 0, 0, 1'b0);
      // Bad checksum, then a good packet
      q = {8'h55};
      send_packet(8'h03, 8'h01, q, 8'h00, 0, 0, 1'b0);
      check("badchk_no_valid", pkt_valid, 1'b0);
      q = {8'hA5, 8'h00, 8'h7E};
      send_packet(8'h44, 8'h03, q, model_chk(8'h44, 8'h03, q), 0, 0, 1'b0);
      // Length error
      q = {};
      send_packet(8'h07, 8'h11, q, 8'h00, 0, 0, 1'b0);
      check("lenerr_state", dbg_state, IDLE);
      // Noise then zero-length packet
      drive_byte(8'h00);
      drive_byte(8'hFF);
      check("noise_state", dbg_state, IDLE);
      send_packet(8'h09, 8'h00, q, 8'h09, 0, 0, 1'b0);
      // Overrun: two dropped bytes while held, plus one on the ack cycle
      q = {8'h01, 8'h02, 8'h03, 8'h04};
      send_packet(8'h5A, 8'h04, q, model_chk(8'h5A, 8'h04, q), 0, 2, 1'b1);
      // Reset in the middle of the payload
      drive_byte(8'hA5);
      drive_byte(8'h21);
      drive_byte(8'h04);
      drive_byte(8'h10);
      drive_byte(8'h20);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_outputs", {pkt_valid, pkt_err, err_code, overrun}, 5'b0);
      check("midrst_cmd_len", {pkt_cmd, pkt_len}, 16'h0000);
      check("midrst_state", dbg_state, IDLE);
      idle(2);

      // Inter-byte gap after LEN strobe
      drive_byte(8'hA5);
`ifdef UART_PARSER_TIMEOUT_EN
      exp_q.push_back(evt(K_ERR, ERR_TIMEOUT, 8'd0, 8'd0, cyc + 1 + TMO));
      drive_byte(8'h03);
      idle(TMO + 10);
      check("tmo_state", dbg_state, IDLE);
`else
      drive_byte(8'h03);
      idle(150);
      check("no_tmo_state", dbg_state, LEN);
      drive_byte(8'h01);
      drive_byte(8'h5A);
      exp_q.push_back(evt(K_PKT, 2'b00, 8'h03, 8'h01, cyc + 1));
      exp_pay_q.push_back(8'h5A);
      drive_byte(8'h03 ^ 8'h01 ^ 8'h5A);
      consume(0, 1'b0);
`endif

      // Randomized packets
      for (int n = 0; n < 60; n++) begin
         cmd = 8'($urandom);
         r   = $urandom_range(0, 9);
         if (r == 0)      len = 8'd0;
         else if (r == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
         else if (r == 2) len = 8'(MAX_LEN);
         else             len = 8'($urandom_range(1, MAX_LEN));
         q = {};
         if (int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
         end
         chk = model_chk(cmd, len, q);
         if ($urandom_range(0, 5) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         send_packet(cmd, len, q, chk, $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 3) == 0);
      end

      idle(5);
      check("exp_q_empty", exp_q.size(), 0);
      check("exp_pay_q_empty", exp_pay_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Consumes bytes from the UART receive path: 8-bit rx_data plus a one-cycle data_ready strobe.
- Frames the byte stream into command packets: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
- Buffers the payload, checks it, then presents a validated packet to the acoustics control logic with a valid/ack handshake.
- Reports framing and checksum errors as one-cycle pulses.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-packet marker
- MAX_LEN, 16, maximum payload bytes accepted (1..255)
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes inside a packet (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_data  in  8  received byte; valid only while data_ready=1
- data_ready  in  1  one-cycle strobe, new byte on rx_data
- pkt_valid  out  1  validated packet available; held until pkt_ack
- pkt_ack  in  1  consumer releases the packet
- pkt_cmd  out  8  command byte of the held packet
- pkt_len  out  8  payload length of the held packet
- rd_addr  in  $clog2(MAX_LEN)  payload read address
- rd_data  out  8  payload byte at rd_addr, combinational read
- pkt_err  out  1  one-cycle pulse: packet aborted
- err_code  out  2  reason, valid with pkt_err: 01 bad LEN, 10 bad CHK, 11 timeout
- overrun  out  1  one-cycle pulse: byte dropped while pkt_valid held

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - state=IDLE; pkt_valid, pkt_err, overrun, err_code=0; pkt_cmd, pkt_len, byte counter, running checksum=0.
  - Payload buffer contents are not reset.
  - Reset mid-packet discards the partial packet with no pkt_err.
- Only cycles with data_ready=1 advance the FSM. All other cycles hold state, apart from the timeout counter.
- States and transitions, all on data_ready:
  - IDLE: rx_data==SYNC_BYTE -> CMD; any other byte is ignored and stays in IDLE.
  - CMD: latch cmd; chk = rx_data -> LEN.
  - LEN:
    - rx_data > MAX_LEN -> pulse pkt_err, err_code=01 -> IDLE.
    - rx_data == 0 -> CHK.
    - otherwise latch len, cnt=0 -> PAYLOAD.
    - In all cases chk ^= rx_data.
  - PAYLOAD: buf[cnt] = rx_data; chk ^= rx_data; cnt++. When cnt reaches len-1 on this byte -> CHK.
  - CHK:
    - rx_data == chk -> DONE; pkt_valid=1 on the next cycle.
    - mismatch -> pulse pkt_err, err_code=10 -> IDLE.
  - DONE:
    - pkt_valid=1; pkt_cmd and pkt_len stable; buffer frozen.
    - pkt_ack=1 -> pkt_valid=0 the next cycle -> IDLE.
    - data_ready while in DONE: byte dropped, overrun pulses for one cycle. This includes the cycle pkt_ack is sampled, so the byte is not re-parsed.
- pkt_ack outside DONE is ignored.
- The checksum is the XOR of CMD, LEN and all payload bytes. SYNC and CHK are excluded.
- Latency: pkt_valid rises exactly 1 clk after the data_ready cycle carrying a correct CHK byte. pkt_err pulses 1 clk after the offending byte.
- A SYNC_BYTE value appearing inside CMD, LEN, PAYLOAD or CHK is treated as data; there is no resync.
- rd_data reflects buf[rd_addr]. Reads with rd_addr >= pkt_len return stale data and are legal.
- err_code holds its last value between pulses; it is meaningful only when pkt_err=1.

Optional Feature:
- Macro: UART_PARSER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in CMD, LEN, PAYLOAD and CHK; it clears on every data_ready and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: pulse pkt_err, err_code=11, return to IDLE.
  - If data_ready arrives in the same cycle as the limit, the byte wins and no timeout fires.
- Undefined: no counter logic is generated, err_code 11 never occurs, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, CMD, LEN, PAYLOAD, CHK, DONE)
  - err_code constants ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TIMEOUT=2'b11
  - default SYNC_BYTE
- One sub-module, uart_payload_buf: MAX_LEN x 8 register file with a synchronous write port and an asynchronous read port.
- FSM and checksum logic stay in the top module.

Test Plan:
- Good packet: A5, 03, 02, 11, 22, (03^02^11^22 = 32) -> pkt_valid=1 one clk after the CHK byte; pkt_cmd=03, pkt_len=02; rd_addr 0/1 -> 11/22; pkt_ack -> pkt_valid=0 next cycle.
- Bad checksum: A5, 03, 01, 55, 00 -> pkt_err pulse with err_code=10; pkt_valid stays 0; a following good packet is accepted.
- Length error (MAX_LEN=16): A5, 07, 11 -> pkt_err, err_code=01 after the LEN byte; FSM in IDLE.
- Zero length and noise: bytes 00, FF, then A5, 09, 00, 09 -> leading noise ignored; pkt_valid with pkt_len=0, pkt_cmd=09.
- Overrun: while pkt_valid is held, send 2 bytes -> two overrun pulses; pkt_cmd, pkt_len and buffer unchanged. Reset asserted mid-PAYLOAD -> all outputs 0 next cycle and no pkt_err.
- With UART_PARSER_TIMEOUT_EN defined and TIMEOUT_CYCLES=100: send A5, 03 then idle -> pkt_err with err_code=11 exactly 100 clks after the 03 strobe. With the macro undefined -> FSM waits in LEN indefinitely.
